// File: rtl/i2c_dma_ctrl_if.sv
// DMA request/acknowledge handshake between the I2C data-path sequencer and the system DMA.
interface i2c_dma_ctrl_if;
  logic dma_req;
  logic dma_ack;

  modport master (output dma_req, input dma_ack);
  modport slave  (input dma_req, output dma_ack);
endinterface

// File: rtl/i2c_dma_ctrl.sv
// I2C DMA request sequencer: one req/ack handshake per byte, down-counted transfer length,
// end-of-transfer and error-abort pulses. Optional last-byte NACK via I2C_DMA_LAST_EN.
module i2c_dma_ctrl #(
  parameter int unsigned NDT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_dmaen_i,
  input  logic             ndt_load_i,
  input  logic [NDT_W-1:0] ndt_i,
  input  logic             rr_tra_i,
  input  logic             rr_txe_i,
  input  logic             rr_rxne_i,
  input  logic             rw_berr_i,
  input  logic             rw_arlo_i,
  input  logic             rw_af_i,
  i2c_dma_ctrl_if.master   dma,
  output logic [NDT_W-1:0] ndt_o,
  output logic             busy_o,
  output logic             eot_o,
  output logic             abort_o,
  output logic             ack_clr_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_CLR = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NDT_W-1:0] ndt_q, ndt_d;
  logic             tra_q, tra_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             eot_q, eot_d;
  logic             abort_q, abort_d;
  logic             ack_clr_q, ack_clr_d;

  logic err;
  logic flag_idle;
  logic flag_act;
  logic ack_take;
  logic ndt_nz;

  assign err       = rw_berr_i | rw_arlo_i | rw_af_i;
  // In IDLE the live direction picks the flag; once a byte starts the latched one does.
  assign flag_idle = rr_tra_i ? rr_txe_i : rr_rxne_i;
  assign flag_act  = tra_q ? rr_txe_i : rr_rxne_i;
  assign ndt_nz    = (ndt_q != '0);
  assign ack_take  = (state_q == REQ) & dma.dma_ack;

  always_comb begin
    state_d   = state_q;
    ndt_d     = ndt_q;
    tra_d     = tra_q;
    eot_d     = 1'b0;
    abort_d   = 1'b0;
    ack_clr_d = 1'b0;

    // An ack coinciding with an abort still consumes its byte.
    if (ack_take && ndt_nz) begin
      ndt_d = ndt_q - NDT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (ndt_load_i) begin
          ndt_d = ndt_i;
        end else if (cfg_dmaen_i && flag_idle && ndt_nz && !err) begin
          state_d = REQ;
          tra_d   = rr_tra_i;
        end
      end
      REQ: begin
        if (err || !cfg_dmaen_i) begin
          state_d = IDLE;
          abort_d = err;
        end else if (dma.dma_ack) begin
          state_d = WAIT_CLR;
        end
      end
      WAIT_CLR: begin
        if (err || !cfg_dmaen_i) begin
          state_d = IDLE;
          abort_d = err;
        end else if (!flag_act) begin
          state_d = IDLE;
          eot_d   = !ndt_nz;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef I2C_DMA_LAST_EN
    ack_clr_d = (ack_take && !tra_q && (ndt_q == NDT_W'(2)))
              | ((state_q == IDLE) && ndt_load_i && !rr_tra_i && (ndt_i == NDT_W'(1)));
`else
    ack_clr_d = 1'b0;
`endif

    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ndt_q     <= '0;
      tra_q     <= 1'b0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      eot_q     <= 1'b0;
      abort_q   <= 1'b0;
      ack_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ndt_q     <= ndt_d;
      tra_q     <= tra_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      eot_q     <= eot_d;
      abort_q   <= abort_d;
      ack_clr_q <= ack_clr_d;
    end
  end

  assign dma.dma_req = req_q;
  assign ndt_o       = ndt_q;
  assign busy_o      = busy_q;
  assign eot_o       = eot_q;
  assign abort_o     = abort_q;
  assign ack_clr_o   = ack_clr_q;

endmodule

// File: tb/tb_i2c_dma_ctrl.sv
// Directed self-checking bench for i2c_dma_ctrl; expectations follow the I2C_DMA_LAST_EN setting.
module tb_i2c_dma_ctrl;

  localparam int unsigned NDT_W = 16;

`ifdef I2C_DMA_LAST_EN
  localparam logic LAST_EN = 1'b1;
`else
  localparam logic LAST_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_dmaen, ndt_load, rr_tra, rr_txe, rr_rxne;
  logic             rw_berr, rw_arlo, rw_af;
  logic [NDT_W-1:0] ndt_in;
  logic [NDT_W-1:0] ndt_out;
  logic             busy, eot, abort, ack_clr;

  int errors = 0;
  int checks = 0;

  i2c_dma_ctrl_if dma_if ();

  i2c_dma_ctrl #(.NDT_W(NDT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_dmaen_i (cfg_dmaen),
    .ndt_load_i  (ndt_load),
    .ndt_i       (ndt_in),
    .rr_tra_i    (rr_tra),
    .rr_txe_i    (rr_txe),
    .rr_rxne_i   (rr_rxne),
    .rw_berr_i   (rw_berr),
    .rw_arlo_i   (rw_arlo),
    .rw_af_i     (rw_af),
    .dma         (dma_if.master),
    .ndt_o       (ndt_out),
    .busy_o      (busy),
    .eot_o       (eot),
    .abort_o     (abort),
    .ack_clr_o   (ack_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [NDT_W-1:0] n);
    ndt_in   = n;
    ndt_load = 1'b1;
    tick();
    ndt_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_dmaen = 1'b0; ndt_load = 1'b0; ndt_in = '0;
    rr_tra = 1'b1; rr_txe = 1'b0; rr_rxne = 1'b0;
    rw_berr = 1'b0; rw_arlo = 1'b0; rw_af = 1'b0;
    dma_if.dma_ack = 1'b0;
    tick(); tick();
    check("rst_req",   {31'd0, dma_if.dma_req}, 32'd0);
    check("rst_ndt",   {16'd0, ndt_out}, 32'd0);
    check("rst_flags", {28'd0, busy, eot, abort, ack_clr}, 32'd0);
    rst = 1'b0;
    tick();

    // Tx, ndt=3, ack two cycles after each request
    cfg_dmaen = 1'b1; rr_tra = 1'b1;
    load(16'd3);
    check("tx_load_ndt", {16'd0, ndt_out}, 32'd3);
    check("tx_load_idle", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      rr_txe = 1'b1;
      tick();
      check("tx_req_rise", {30'd0, dma_if.dma_req, busy}, 32'd3);
      tick();
      check("tx_req_hold", {31'd0, dma_if.dma_req}, 32'd1);
      dma_if.dma_ack = 1'b1;
      tick();
      dma_if.dma_ack = 1'b0;
      check("tx_req_fall", {31'd0, dma_if.dma_req}, 32'd0);
      check("tx_ndt_dec", {16'd0, ndt_out}, 32'(2 - k));
      tick();
      check("tx_wait_noreq", {30'd0, dma_if.dma_req, busy}, 32'd1);
      rr_txe = 1'b0;
      tick();
      check("tx_eot", {30'd0, eot, busy}, (k == 2) ? 32'd2 : 32'd0);
      tick();
      check("tx_eot_pulse", {31'd0, eot}, 32'd0);
    end

    // Flag stuck high for 5 cycles after ack: no second request, single decrement
    load(16'd2);
    rr_txe = 1'b1;
    tick();
    dma_if.dma_ack = 1'b1;
    tick();
    dma_if.dma_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stale_flag", {14'd0, dma_if.dma_req, busy, ndt_out}, {14'd0, 1'b0, 1'b1, 16'd1});
    end
    rr_txe = 1'b0;
    tick();
    check("stale_release", {30'd0, busy, eot}, 32'd0);

    // AF while in REQ with ndt=2
    load(16'd2);
    rr_txe = 1'b1;
    tick();
    check("af_req", {31'd0, dma_if.dma_req}, 32'd1);
    rw_af = 1'b1;
    tick();
    rw_af = 1'b0; rr_txe = 1'b0;
    check("af_abort", {29'd0, dma_if.dma_req, abort, eot}, 32'd2);
    check("af_ndt", {16'd0, ndt_out}, 32'd2);
    tick();
    check("af_abort_pulse", {30'd0, abort, busy}, 32'd0);

    // Disable in WAIT_CLR; load while busy ignored
    rr_txe = 1'b1;
    tick();
    dma_if.dma_ack = 1'b1;
    tick();
    dma_if.dma_ack = 1'b0;
    load(16'd7);
    check("busy_load_ign", {15'd0, busy, ndt_out}, {15'd0, 1'b1, 16'd1});
    cfg_dmaen = 1'b0;
    tick();
    check("dis_idle", {29'd0, busy, abort, eot}, 32'd0);
    check("dis_ndt_hold", {16'd0, ndt_out}, 32'd1);

    // Ack in the same cycle as a bus error: counted, no eot
    cfg_dmaen = 1'b1;
    tick();
    check("berr_req", {31'd0, dma_if.dma_req}, 32'd1);
    rw_berr = 1'b1; dma_if.dma_ack = 1'b1;
    tick();
    rw_berr = 1'b0; dma_if.dma_ack = 1'b0; rr_txe = 1'b0;
    check("berr_ack_abort", {29'd0, busy, abort, eot}, 32'd2);
    check("berr_ack_ndt", {16'd0, ndt_out}, 32'd0);

    // Stray ack in IDLE is ignored
    load(16'd2);
    dma_if.dma_ack = 1'b1;
    tick();
    dma_if.dma_ack = 1'b0;
    check("stray_ack", {15'd0, busy, ndt_out}, {15'd0, 1'b0, 16'd2});

    // Rx, ndt=4: ack_clr only on the 2->1 decrement; direction latched per byte
    rr_tra = 1'b0;
    load(16'd4);
    check("rx_load_noclr", {31'd0, ack_clr}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      rr_rxne = 1'b1;
      tick();
      check("rx_req", {31'd0, dma_if.dma_req}, 32'd1);
      if (k == 0) rr_tra = 1'b1;
      dma_if.dma_ack = 1'b1;
      tick();
      dma_if.dma_ack = 1'b0;
      check("rx_ndt", {16'd0, ndt_out}, 32'(3 - k));
      check("rx_ack_clr", {31'd0, ack_clr}, (k == 2) ? {31'd0, LAST_EN} : 32'd0);
      if (k == 0) begin
        tick();
        check("rx_dir_latched", {31'd0, busy}, 32'd1);
        rr_tra = 1'b0;
      end
      rr_rxne = 1'b0;
      tick();
      check("rx_byte_done", {29'd0, busy, ack_clr, eot}, (k == 3) ? 32'd1 : 32'd0);
    end

    // Rx load of 1 requests the NACK up front
    load(16'd1);
    check("rx_load1_clr", {31'd0, ack_clr}, {31'd0, LAST_EN});
    tick();
    check("rx_load1_pulse", {31'd0, ack_clr}, 32'd0);
    rr_rxne = 1'b1;
    tick();
    dma_if.dma_ack = 1'b1;
    tick();
    dma_if.dma_ack = 1'b0; rr_rxne = 1'b0;
    check("rx_1to0_noclr", {15'd0, ack_clr, ndt_out}, 32'd0);
    tick();
    check("rx_load1_eot", {31'd0, eot}, 32'd1);

    // Asynchronous reset mid-REQ
    rr_tra = 1'b1;
    load(16'd3);
    rr_txe = 1'b1;
    tick();
    check("pre_rst_req", {31'd0, dma_if.dma_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {11'd0, dma_if.dma_req, busy, eot, abort, ack_clr, ndt_out}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    check("post_rst_noreq", {15'd0, dma_if.dma_req, ndt_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_dma_ctrl.md
# i2c_dma_ctrl

DMA request sequencer for the I2C data register. It watches the SR1 data-path flags (TXE/RXNE), issues one request/acknowledge handshake per byte toward the system DMA, and counts down a programmed transfer length. At end of transfer it raises an end-of-transfer pulse, and it aborts cleanly on bus errors. It sits between the SR1 status logic and the DMA interface, beside the CR1/CR2 register file.

## Interface
Parameters:
- NDT_W, 16, width of the transfer counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- cfg_dmaen_i  in  1  DMA enable (CR2.DMAEN); clearing it aborts any transfer
- ndt_load_i  in  1  single-cycle pulse that loads ndt_i
- ndt_i  in  NDT_W  transfer length in bytes
- rr_tra_i  in  1  transfer direction: 1 = tx, 0 = rx
- rr_txe_i  in  1  DR empty (tx)
- rr_rxne_i  in  1  DR full (rx)
- rw_berr_i, rw_arlo_i, rw_af_i  in  1 each  error flags; level-sensitive abort
- dma_req_o  out  1  DMA request
- dma_ack_i  in  1  DMA acknowledge; the DR access completes in the same cycle
- ndt_o  out  NDT_W  remaining byte count
- busy_o  out  1  state != IDLE
- eot_o  out  1  one-cycle end-of-transfer pulse
- abort_o  out  1  one-cycle pulse on error abort
- ack_clr_o  out  1  one-cycle pulse to clear CR1.ACK (see Configuration)

## Operation
- States: IDLE, REQ, WAIT_CLR.
- Active flag: flag = rr_tra_i ? rr_txe_i : rr_rxne_i.
- Error term: err = rw_berr_i | rw_arlo_i | rw_af_i.
- IDLE -> REQ when cfg_dmaen_i & flag & ndt != 0 & ~err.
- REQ: dma_req_o = 1. The block holds this state until it samples dma_ack_i = 1. The acknowledge cycle then:
  - decrements ndt;
  - goes to WAIT_CLR.
- WAIT_CLR: no request is issued. The block holds this state while flag = 1, which prevents a double request on a stale flag.
  - When flag = 0 and the new ndt = 0: pulse eot_o and go to IDLE.
  - When flag = 0 and ndt != 0: go to IDLE, which re-arms the request.
- Abort: err = 1 or cfg_dmaen_i = 0, in any state other than IDLE.
  - Go to IDLE; dma_req_o drops the next cycle; ndt holds its value.
  - abort_o pulses only for err, not for a disable.
  - A dma_ack_i arriving in the same cycle as the abort is honored for the count (ndt decrements) but raises no eot_o.
- ndt_load_i is accepted only in IDLE and ignored otherwise. Loading 0 leaves the block idle.
- The direction is sampled on IDLE -> REQ. A change of rr_tra_i mid-byte is ignored until the next IDLE.
- ndt arithmetic is unsigned and never wraps below 0.

## Timing
- Reset values: state = IDLE, dma_req_o = 0, ndt_o = 0, busy_o = 0, eot_o = 0, abort_o = 0, ack_clr_o = 0.
- All outputs are registered.
- dma_req_o rises 1 cycle after flag is sampled high in IDLE.
- dma_req_o falls on the clock edge that samples dma_ack_i. In that same edge ndt_o updates.
- eot_o asserts on the edge that leaves WAIT_CLR with ndt = 0. The minimum per-byte cycle is 3 clocks: IDLE, REQ (ack in the first cycle), WAIT_CLR (flag already low).
- The DMA must not assert dma_ack_i while dma_req_o = 0. Any such acknowledge is ignored.

## Configuration
- I2C_DMA_LAST_EN, defined: automatic NACK on the last received byte.
  - In rx (rr_tra_i = 0), ack_clr_o pulses for one cycle when ndt transitions 2 -> 1.
  - It also pulses 1 cycle after a load of ndt_i = 1 while rr_tra_i = 0.
  - The register file then clears CR1.ACK, so the final byte is NACKed.
- Undefined: ack_clr_o is tied to 0 and software manages ACK.

## Test plan
- Tx, ndt = 3, txe high, DMA acks 2 cycles after each request -> three req/ack handshakes, ndt_o goes 2, 1, 0, and eot_o pulses once after the third txe clears.
- Rx with I2C_DMA_LAST_EN, ndt = 4 -> ack_clr_o pulses exactly once, on the 2 -> 1 decrement. With the macro undefined, it never pulses.
- Flag held high for 5 cycles after ack -> no second request until the flag drops, and the count is not decremented twice.
- rw_af_i asserted while in REQ with ndt = 2 -> dma_req_o low next cycle, abort_o pulses, ndt_o stays 2, and no eot_o.
- cfg_dmaen_i cleared in WAIT_CLR -> IDLE, no abort_o, ndt holds. ndt_load_i issued while busy is ignored.
- Reset asserted mid-REQ -> all outputs return to their reset values immediately (asynchronous). After release, no request is issued until a new ndt is loaded.
